bit_monitor: RTL and testbench

Hardware checker that samples a single-bit signal driven by a constant or slow-changing source (e.g. `setbit`) and reports pass/fail on chip, without relying on a simulator. It sits on the receiving end of the constant-bit source:
- on `start`, it waits a settling interval;
- it then compares `din` against an expected level for a fixed window, counting mismatches;
- it presents a latched `ok`/`err` verdict to LEDs or a status register.

---
 rtl/bit_monitor_if.sv | 31 +++
 rtl/bit_monitor.sv | 137 +++++++++++++
 tb/tb_bit_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bit_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_monitor_if
// Description : Status/stimulus bundle between a constant-bit checker and
//               whoever drives it (start/din in, verdict and count out).
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_monitor_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             din;
  logic             busy;
  logic             done;
  logic             ok;
  logic             err;
  logic [CNT_W-1:0] err_count;

  // Side that launches checks and reads the verdict
  modport master (
    output start, din,
    input  busy, done, ok, err, err_count
  );

  // The checker itself
  modport slave (
    input  start, din,
    output busy, done, ok, err, err_count
  );
endinterface
`default_nettype wire

// File: rtl/bit_monitor.sv
`default_nettype none
// ============================================================================
// Module      : bit_monitor
// Description : On-chip checker for a constant/slow single-bit source. After
//               start it waits SETTLE cycles, compares din with EXPECTED for
//               WINDOW cycles counting mismatches, then latches ok/err.
//               Optional macro BIT_MONITOR_SATURATE_EN makes err_count
//               saturate instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_monitor #(
  parameter int EXPECTED = 1,
  parameter int SETTLE   = 10,
  parameter int WINDOW   = 4,
  parameter int CNT_W    = 8
) (
  input  wire          clk,
  input  wire          rst,
  bit_monitor_if.slave mon
);

  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int WIN_W = (WINDOW > 0) ? $clog2(WINDOW + 1) : 1;
  localparam logic EXP_BIT = (EXPECTED != 0);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((WINDOW > 0) ? WINDOW - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE_ST = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [SET_W-1:0] settle_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic             sticky_miss;
  logic [CNT_W-1:0] err_count;
  logic             busy;
  logic             done;
  logic             ok;
  logic             err;

  logic             miss;
  logic [CNT_W-1:0] count_inc;

  // Per-sample mismatch and the next mismatch count (wrap or saturate)
  always_comb begin
    miss      = (mon.din != EXP_BIT);
    count_inc = err_count + 1'b1;
`ifdef BIT_MONITOR_SATURATE_EN
    if (&err_count) begin
      count_inc = err_count;
    end
`else
    count_inc = err_count + 1'b1;
`endif
  end

  // Sequencer: IDLE -> SETTLE -> CHECK -> DONE with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      win_cnt     <= '0;
      sticky_miss <= 1'b0;
      err_count   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ok          <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        // A fresh start looks identical from IDLE and from DONE
        IDLE, DONE: begin
          if (mon.start) begin
            state       <= (SETTLE == 0) ? CHECK : SETTLE_ST;
            settle_cnt  <= '0;
            win_cnt     <= '0;
            sticky_miss <= 1'b0;
            err_count   <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            ok          <= 1'b0;
            err         <= 1'b0;
          end
        end

        // din is deliberately ignored while the source settles
        SETTLE_ST: begin
          if (settle_cnt == SET_LAST) begin
            settle_cnt <= '0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        CHECK: begin
          if (miss) begin
            err_count   <= count_inc;
            sticky_miss <= 1'b1;
          end
          if (win_cnt == WIN_LAST) begin
            win_cnt <= '0;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            // Verdict comes from the sticky flag so a wrapped count of
            // zero still reports a failure
            ok      <= ~(sticky_miss | miss);
            err     <= sticky_miss | miss;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          ok    <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  assign mon.busy      = busy;
  assign mon.done      = done;
  assign mon.ok        = ok;
  assign mon.err       = err;
  assign mon.err_count = err_count;

endmodule
`default_nettype wire

// File: tb/tb_bit_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_monitor
// Description : Self-checking bench for bit_monitor: table of directed runs
//               on the default configuration plus hand sequences for restart,
//               reset mid-run, counter overflow and SETTLE=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default configuration
  bit_monitor_if #(.CNT_W(8)) bus_a ();
  bit_monitor #(.EXPECTED(1), .SETTLE(10), .WINDOW(4), .CNT_W(8))
    dut_a (.clk(clk), .rst(rst), .mon(bus_a.slave));

  // Narrow counter, long window
  bit_monitor_if #(.CNT_W(2)) bus_b ();
  bit_monitor #(.EXPECTED(1), .SETTLE(2), .WINDOW(6), .CNT_W(2))
    dut_b (.clk(clk), .rst(rst), .mon(bus_b.slave));

  // No settling, single sample, expect low
  bit_monitor_if #(.CNT_W(8)) bus_c ();
  bit_monitor #(.EXPECTED(0), .SETTLE(0), .WINDOW(1), .CNT_W(8))
    dut_c (.clk(clk), .rst(rst), .mon(bus_c.slave));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic       din_settle;
    logic [3:0] pat;       // din at CHECK sample i = pat[i]
    int         exp_ok;
    int         exp_err;
    int         exp_cnt;
  } vec_t;

  // Full run on dut_a, started from IDLE or DONE
  task automatic run_a(input vec_t v);
    bus_a.start = 1'b1;
    bus_a.din   = v.din_settle;
    tick();
    chk({v.name, " busy_after_k"}, int'(bus_a.busy), 1);
    chk({v.name, " done_after_k"}, int'(bus_a.done), 0);
    bus_a.start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      bus_a.din = (c <= 10) ? v.din_settle : v.pat[c-11];
      tick();
      if (c == 13) begin
        chk({v.name, " busy_k13"}, int'(bus_a.busy), 1);
        chk({v.name, " done_k13"}, int'(bus_a.done), 0);
      end
    end
    chk({v.name, " done"},  int'(bus_a.done), 1);
    chk({v.name, " busy"},  int'(bus_a.busy), 0);
    chk({v.name, " ok"},    int'(bus_a.ok),   v.exp_ok);
    chk({v.name, " err"},   int'(bus_a.err),  v.exp_err);
    chk({v.name, " count"}, int'(bus_a.err_count), v.exp_cnt);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"pass_const1",   1'b1, 4'b1111, 1, 0, 0};
    vecs[1] = '{"fail_const0",   1'b0, 4'b0000, 0, 1, 4};
    vecs[2] = '{"settle_ignored",1'b0, 4'b1111, 1, 0, 0};
    vecs[3] = '{"alt_1010",      1'b1, 4'b1010, 0, 1, 2};
    vecs[4] = '{"last_bad",      1'b0, 4'b0111, 0, 1, 1};
    vecs[5] = '{"first_bad",     1'b1, 4'b1110, 0, 1, 1};

    bus_a.start = 1'b0; bus_a.din = 1'b0;
    bus_b.start = 1'b0; bus_b.din = 1'b0;
    bus_c.start = 1'b0; bus_c.din = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst busy",  int'(bus_a.busy), 0);
    chk("rst done",  int'(bus_a.done), 0);
    chk("rst ok",    int'(bus_a.ok),   0);
    chk("rst err",   int'(bus_a.err),  0);
    chk("rst count", int'(bus_a.err_count), 0);
    rst = 1'b0;
    tick();

    // Table-driven runs (each one after the first restarts from DONE)
    for (int i = 0; i < 6; i++) run_a(vecs[i]);

    // Restart from a failing DONE: everything drops at the accept edge
    run_a(vecs[1]);
    bus_a.start = 1'b1; bus_a.din = 1'b1;
    tick();
    bus_a.start = 1'b0;
    chk("restart done",  int'(bus_a.done), 0);
    chk("restart err",   int'(bus_a.err),  0);
    chk("restart count", int'(bus_a.err_count), 0);
    chk("restart busy",  int'(bus_a.busy), 1);
    // start pulse while busy must not stretch the run
    for (int c = 1; c <= 14; c++) begin
      bus_a.start = (c == 5) ? 1'b1 : 1'b0;
      tick();
      if (c == 13) chk("busy_start done_k13", int'(bus_a.done), 0);
    end
    bus_a.start = 1'b0;
    chk("busy_start done_k14", int'(bus_a.done), 1);
    chk("busy_start ok",       int'(bus_a.ok),   1);

    // Reset at edge k+12 with din=0 (count already nonzero)
    bus_a.start = 1'b1; bus_a.din = 1'b0;
    tick();
    bus_a.start = 1'b0;
    for (int c = 1; c <= 11; c++) tick();
    chk("pre_rst count", int'(bus_a.err_count), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy",  int'(bus_a.busy), 0);
    chk("midrst done",  int'(bus_a.done), 0);
    chk("midrst ok",    int'(bus_a.ok),   0);
    chk("midrst err",   int'(bus_a.err),  0);
    chk("midrst count", int'(bus_a.err_count), 0);
    tick();
    run_a(vecs[1]);

    // Overflow: 6 mismatches into a 2-bit counter
    bus_b.start = 1'b1; bus_b.din = 1'b0;
    tick();
    bus_b.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 7) chk("ovf busy_k7", int'(bus_b.busy), 1);
    end
    chk("ovf done", int'(bus_b.done), 1);
    chk("ovf err",  int'(bus_b.err),  1);
    chk("ovf ok",   int'(bus_b.ok),   0);
`ifdef BIT_MONITOR_SATURATE_EN
    chk("ovf count", int'(bus_b.err_count), 3);
`else
    chk("ovf count", int'(bus_b.err_count), 2);
`endif

    // SETTLE=0, WINDOW=1, EXPECTED=0
    bus_c.start = 1'b1; bus_c.din = 1'b0;
    tick();
    bus_c.start = 1'b0;
    chk("s0 busy_k",  int'(bus_c.busy), 1);
    chk("s0 done_k",  int'(bus_c.done), 0);
    tick();
    chk("s0 done_k1", int'(bus_c.done), 1);
    chk("s0 ok",      int'(bus_c.ok),   1);
    chk("s0 err",     int'(bus_c.err),  0);
    bus_c.start = 1'b1; bus_c.din = 1'b1;
    tick();
    bus_c.start = 1'b0;
    tick();
    chk("s0 bad done",  int'(bus_c.done), 1);
    chk("s0 bad err",   int'(bus_c.err),  1);
    chk("s0 bad count", int'(bus_c.err_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
